spi_frame_ctrl: RTL
===================

// Module: spi_frame_ctrl
// PURPOSE
//  Frame controller for the 8192-bit SPI slave: builds the tx frame from photon-counter results,
//  holds it stable for a whole SS-low transfer, validates/decodes the rx frame at SS release.
//  Sits between the counter bank and the SPI slave; drives acquisition config to the counters.
// PARAMETERS
//  FRAME_W  8192  SPI frame width in bits (must equal slave buffer width)
//  N_CH     16    photon-counter channels packed into tx frame
//  CNT_W    32    bits per channel count; N_CH*CNT_W <= FRAME_W-32
// PORTS
//  sysClk       in   1              system clock
//  rst_n        in   1              asynchronous active-low reset
//  spi_ss       in   1              raw SPI SS (active low), synchronised internally
//  spi_sclk     in   1              raw SPI SCLK, synchronised internally for bit count
//  rx           in   FRAME_W        received frame from SPI slave
//  tx           out  FRAME_W        frame to SPI slave
//  cnt_data     in   N_CH*CNT_W     counter results, ch0 in MSBs
//  cnt_valid    in   1              1-cycle pulse: cnt_data complete
//  acq_run      out  1              acquisition enabled (level)
//  acq_start    out  1              1-cycle pulse on START command
//  cfg_int_time out  32             integration time in sysClk cycles
//  cfg_pattern  out  16             DMD/pattern index for next acquisition
//  cmd_valid    out  1              1-cycle pulse: valid command decoded
//  err_frame    out  1              1-cycle pulse: short frame or bad header
// BEHAVIOUR
//  Reset: tx=0, acq_run=0, all pulses 0, cfg_int_time=32'd1000, cfg_pattern=0, seq=0, flags=0.
//  SS/SCLK: 3-FF sync, edge detect as in slave (same latency, so edges align with slave state).
//  tx format (MSB first): [W-1:W-8]=8'hA5, [W-9:W-16]=seq, [W-17:W-24]=status
//    {fresh,overrun,last_err,acq_run,4'b0}, [W-25:W-32]=CRC8 or 8'h00, then counts, zero pad.
//  Pending buffer: cnt_valid loads cnt_data into pend, sets pend_full; if pend_full already set,
//    overwrite and set overrun (cleared when next frame snapshots).
//  FSM: IDLE -> (SS falling) XFER -> (SS rising) DECODE -> IDLE (DECODE lasts 1 cycle).
//  IDLE->XFER, same cycle: if pend_full: tx<=pend frame, seq<=seq+1, fresh=1, pend_full<=0;
//    else tx resent with fresh=0 and unchanged seq. tx constant throughout XFER.
//  XFER: bitcnt (14b, saturating at FRAME_W) increments per synced SCLK rising; cnt_valid still
//    goes to pend only.
//  DECODE: valid iff bitcnt==FRAME_W and rx[W-1:W-8]==8'h5A; opcode=rx[W-9:W-16],
//    payload=rx[W-17:W-48]. Invalid -> err_frame pulse, last_err=1, no config change.
//    0x00 NOP; 0x01 START: acq_run=1, acq_start pulse; 0x02 STOP: acq_run=0;
//    0x03 SET_INT: cfg_int_time=payload (0 treated as 1); 0x04 SET_PAT: cfg_pattern=payload[15:0];
//    other: err_frame. Valid -> cmd_valid pulse, last_err=0. Pulses 1 cycle after SS rising sync.
//  SS falling seen in DECODE/XFER edge same cycle: SS rising wins, next falling handled from IDLE.
//  rst_n asserted mid-transfer: immediate return to IDLE/reset values; partial frame discarded.
//  Seq wraps 8'hFF -> 8'h00.
// CONFIGURATION
//  SPI_CRC_EN defined: tx CRC8 (poly 0x07, init 0x00) over bits [W-33:0] computed at snapshot
//    (combinational over pend, or registered when cnt_valid loads pend); rx must carry CRC8 of
//    rx[W-49:0]... over payload bits [W-17:W-48] in [W-49:W-56], mismatch -> err_frame.
//  Undefined: CRC fields 8'h00 on tx, ignored on rx.
// STRUCTURE
//  Package spi_frame_pkg: header constants 8'hA5/8'h5A, opcode localparams, status bit indices,
//    field offsets, FSM state enum (IDLE, XFER, DECODE).
//  One sub-module: spi_crc8 (parameterised data width, combinational), only with SPI_CRC_EN.
// TESTING
//  cnt_valid with ch0=32'h12345678, then 8192-bit transfer -> tx[8191:8176]=16'hA501, fresh=1,
//    tx[8159:8128]=32'h12345678.
//  Second transfer with no cnt_valid -> same counts, seq=8'h01, fresh=0.
//  Two cnt_valid before transfer -> newest counts sent, overrun=1; next frame overrun=0.
//  rx header 8'h5A, opcode 0x03, payload 32'd5000 -> cmd_valid pulse, cfg_int_time=5000.
//  SS released after 100 bits with opcode 0x01 -> err_frame pulse, acq_run stays 0.
//  rst_n low at bit 4000, then full transfer -> seq restarts, tx=reset-frame then valid.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// rtl/spi_frame_pkg.sv - shared constants, field offsets and FSM state type for the SPI frame controller
package spi_frame_pkg;

  localparam logic [7:0] TX_HDR = 8'hA5;
  localparam logic [7:0] RX_HDR = 8'h5A;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_START   = 8'h01;
  localparam logic [7:0] OP_STOP    = 8'h02;
  localparam logic [7:0] OP_SET_INT = 8'h03;
  localparam logic [7:0] OP_SET_PAT = 8'h04;

  // Status byte bit positions
  localparam int ST_FRESH    = 7;
  localparam int ST_OVERRUN  = 6;
  localparam int ST_LAST_ERR = 5;
  localparam int ST_ACQ_RUN  = 4;

  // Field offsets counted down from the frame MSB
  localparam int OFS_HDR     = 0;
  localparam int OFS_SEQ     = 8;
  localparam int OFS_STATUS  = 16;
  localparam int OFS_CRC     = 24;
  localparam int OFS_BODY    = 32;
  localparam int OFS_OPCODE  = 8;
  localparam int OFS_PAYLOAD = 16;
  localparam int OFS_RX_CRC  = 48;

  localparam logic [31:0] INT_TIME_RST = 32'd1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    DECODE = 2'd2
  } state_t;

  function automatic logic [7:0] make_status(input logic fresh, input logic overrun,
                                             input logic last_err, input logic run);
    logic [7:0] s;
    s = 8'h00;
    s[ST_FRESH]    = fresh;
    s[ST_OVERRUN]  = overrun;
    s[ST_LAST_ERR] = last_err;
    s[ST_ACQ_RUN]  = run;
    return s;
  endfunction

endpackage

// File: rtl/spi_crc8.sv
// rtl/spi_crc8.sv - combinational CRC8 (poly 0x07, init 0x00, MSB first), used only when SPI_CRC_EN is defined
module spi_crc8 #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  output logic [7:0]        crc
);

  always_comb begin
    crc = 8'h00;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ data[i]) ? 8'h07 : 8'h00);
    end
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// rtl/spi_frame_ctrl.sv - SPI frame controller: tx frame snapshot per SS-low transfer, rx command decode at SS release
// Optional feature macro: SPI_CRC_EN (tx CRC8 over the count body, rx CRC8 check over the payload)
module spi_frame_ctrl
  import spi_frame_pkg::*;
#(
  parameter int FRAME_W = 8192,
  parameter int N_CH    = 16,
  parameter int CNT_W   = 32
) (
  input  logic                   sysClk,
  input  logic                   rst_n,
  input  logic                   spi_ss,
  input  logic                   spi_sclk,
  input  logic [FRAME_W-1:0]     rx,
  output logic [FRAME_W-1:0]     tx,
  input  logic [N_CH*CNT_W-1:0]  cnt_data,
  input  logic                   cnt_valid,
  output logic                   acq_run,
  output logic                   acq_start,
  output logic [31:0]            cfg_int_time,
  output logic [15:0]            cfg_pattern,
  output logic                   cmd_valid,
  output logic                   err_frame
);

  localparam int          CNT_BITS = N_CH * CNT_W;
  localparam int          BODY_W   = FRAME_W - OFS_BODY;
  localparam logic [13:0] BIT_MAX  = 14'(FRAME_W);

  logic [2:0]          ss_sync;
  logic [2:0]          sclk_sync;
  logic                ss_fall;
  logic                ss_rise;
  logic                sclk_rise;
  state_t              state_q;
  state_t              state_d;
  logic                snap;
  logic [13:0]         bitcnt;
  logic [7:0]          seq;
  logic [7:0]          seq_next;
  logic [CNT_BITS-1:0] pend;
  logic                pend_full;
  logic                overrun;
  logic                last_err;
  logic [BODY_W-1:0]   body;
  logic [7:0]          tx_crc;
  logic                rx_crc_ok;
  logic [7:0]          rx_hdr;
  logic [7:0]          opcode;
  logic [31:0]         payload;
  logic                frame_ok;
  logic                op_known;
  logic                unused_rx;

  // Same 3-stage depth as the slave so detected edges line up with its state
  assign ss_fall   =  ss_sync[2]   & ~ss_sync[1];
  assign ss_rise   = ~ss_sync[2]   &  ss_sync[1];
  assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];

  assign snap     = (state_q == IDLE) && ss_fall;
  assign seq_next = seq + 8'd1;

  always_comb begin
    body = '0;
    body[BODY_W-1 -: CNT_BITS] = pend;
  end

  assign rx_hdr  = rx[FRAME_W-1-OFS_HDR -: 8];
  assign opcode  = rx[FRAME_W-1-OFS_OPCODE -: 8];
  assign payload = rx[FRAME_W-1-OFS_PAYLOAD -: 32];

`ifdef SPI_CRC_EN
  logic [7:0] rx_crc_calc;

  spi_crc8 #(.DATA_W(BODY_W)) u_tx_crc (
    .data (body),
    .crc  (tx_crc)
  );

  spi_crc8 #(.DATA_W(32)) u_rx_crc (
    .data (payload),
    .crc  (rx_crc_calc)
  );

  assign rx_crc_ok = (rx_crc_calc == rx[FRAME_W-1-OFS_RX_CRC -: 8]);
`else
  assign tx_crc    = 8'h00;
  assign rx_crc_ok = 1'b1;
`endif

  assign unused_rx = ^rx[FRAME_W-1-OFS_RX_CRC:0];

  assign frame_ok = (bitcnt == BIT_MAX) && (rx_hdr == RX_HDR) && rx_crc_ok;
  assign op_known = (opcode <= OP_SET_PAT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = XFER;
      XFER:    if (ss_rise) state_d = DECODE;
      DECODE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync      <= 3'b111;
      sclk_sync    <= 3'b000;
      state_q      <= IDLE;
      bitcnt       <= '0;
      seq          <= 8'h00;
      pend         <= '0;
      pend_full    <= 1'b0;
      overrun      <= 1'b0;
      last_err     <= 1'b0;
      tx           <= '0;
      acq_run      <= 1'b0;
      acq_start    <= 1'b0;
      cfg_int_time <= INT_TIME_RST;
      cfg_pattern  <= 16'h0000;
      cmd_valid    <= 1'b0;
      err_frame    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[1:0], spi_ss};
      sclk_sync <= {sclk_sync[1:0], spi_sclk};
      state_q   <= state_d;
      cmd_valid <= 1'b0;
      err_frame <= 1'b0;
      acq_start <= 1'b0;

      if (snap) begin
        bitcnt <= '0;
        if (pend_full) begin
          tx        <= {TX_HDR, seq_next, make_status(1'b1, overrun, last_err, acq_run), tx_crc, body};
          seq       <= seq_next;
          pend_full <= 1'b0;
          overrun   <= 1'b0;
        end else begin
          tx[FRAME_W-1 -: 24] <= {TX_HDR, seq, make_status(1'b0, overrun, last_err, acq_run)};
        end
      end

      // A load in the snapshot cycle refills pend after the old contents were taken
      if (cnt_valid) begin
        pend      <= cnt_data;
        pend_full <= 1'b1;
        if (pend_full && !snap) overrun <= 1'b1;
      end

      if (state_q == XFER && sclk_rise && bitcnt != BIT_MAX) bitcnt <= bitcnt + 14'd1;

      if (state_q == DECODE) begin
        if (frame_ok && op_known) begin
          cmd_valid <= 1'b1;
          last_err  <= 1'b0;
          case (opcode)
            OP_START: begin
              acq_run   <= 1'b1;
              acq_start <= 1'b1;
            end
            OP_STOP:    acq_run      <= 1'b0;
            OP_SET_INT: cfg_int_time <= (payload == 32'd0) ? 32'd1 : payload;
            OP_SET_PAT: cfg_pattern  <= payload[15:0];
            default:    ;
          endcase
        end else begin
          err_frame <= 1'b1;
          last_err  <= 1'b1;
        end
      end
    end
  end

endmodule
